// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-requester round-robin arbiter.
// MAX_HOLD and HOLD_W only matter when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  localparam int unsigned N_REQ    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_prio_encoder8.sv
// Rotating-priority 8-to-3 encoder: first set bit of req searching from ptr upward, mod 8.
module rr_prio_encoder8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate so ptr lands on bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant and encoded index.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles (timeout pulse).
module rr_arbiter8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             owner_req;
  logic             hit;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
`endif

  rr_prio_encoder8 u_enc (
    .req (req),
    .ptr (ptr),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    owner_req   = req[gnt_idx];
    hit         = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (enc_any) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = N_REQ'(1) << enc_idx;
          idx_nxt   = enc_idx;
          valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef ARB_TIMEOUT_EN
        hold_nxt = hold_cnt + HOLD_W'(1);
        hit      = (hold_nxt == HOLD_W'(MAX_HOLD));
`endif
        // A dropped request from the owner counts as an implicit release.
        if (rel || !owner_req || hit) begin
          state_nxt   = ST_IDLE;
          ptr_nxt     = gnt_idx + IDX_W'(1);
          gnt_nxt     = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          timeout_nxt = hit && !rel && owner_req;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_nxt;
  end
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner (-1 when idle), rotation pointer, hold count, timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  rr_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input logic r, input logic [7:0] q, input logic l);
    bit hit;
    int c;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      m_hold = 0;
      for (int i = 0; i < 8; i++) begin
        c = (m_ptr + i) % 8;
        if (q[c] && m_owner < 0) m_owner = c;
      end
    end else begin
      m_hold++;
      hit  = TO_EN && (m_hold >= MAXH);
      m_to = hit && !l && q[m_owner];
      if (l || !q[m_owner] || hit) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge(rst, req, rel);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; rel = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got %h want 00", gnt); end
    checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", gnt_idx); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
  endtask

  task automatic test_single_and_skip();
    do_reset();
    req = 8'b0000_0100;
    cycle();
    checks++; if (gnt !== 8'b0000_0100) begin errors++; $display("FAIL single_gnt got %b want 00000100", gnt); end
    checks++; if (gnt_idx !== 3'd2) begin errors++; $display("FAIL single_idx got %0d want 2", gnt_idx); end
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", gnt_valid); end
    rel = 1'b1; req = 8'h00;
    cycle();
    rel = 1'b0;
    checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b/%b want 0/0", gnt, gnt_valid); end
    // ptr is now 3, so bit 0 wins over bit 2.
    req = 8'b0000_0101;
    cycle();
    checks++; if (gnt_idx !== 3'd0 || gnt !== 8'b0000_0001) begin errors++; $display("FAIL skip_first got %0d/%b want 0/00000001", gnt_idx, gnt); end
    rel = 1'b1;
    cycle();
    rel = 1'b0;
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL skip_bubble got %b want 0", gnt_valid); end
    cycle();
    checks++; if (gnt_idx !== 3'd2 || gnt !== 8'b0000_0100) begin errors++; $display("FAIL skip_second got %0d/%b want 2/00000100", gnt_idx, gnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cycle();
      checks++; if (gnt_idx !== 3'(k % 8) || gnt !== (8'h01 << (k % 8)) || gnt_valid !== 1'b1) begin
        errors++; $display("FAIL rr_grant step %0d got idx %0d gnt %b want idx %0d", k, gnt_idx, gnt, k % 8);
      end
      rel = 1'b1;
      cycle();
      rel = 1'b0;
      checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        errors++; $display("FAIL rr_bubble step %0d got %b/%b want 0/0", k, gnt, gnt_valid);
      end
    end
    req = 8'h00;
    rel = 1'b1;
    cycle();
    rel = 1'b0;
  endtask

  task automatic test_implicit_release();
    do_reset();
    req = 8'h20;
    cycle();
    checks++; if (gnt_idx !== 3'd5) begin errors++; $display("FAIL impl_grant got %0d want 5", gnt_idx); end
    req = 8'h41;
    cycle();
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL impl_drop got %b want 0", gnt_valid); end
    cycle();
    checks++; if (gnt_idx !== 3'd6) begin errors++; $display("FAIL impl_ptr got %0d want 6", gnt_idx); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h10;
    cycle();
    checks++; if (gnt_idx !== 3'd4) begin errors++; $display("FAIL midrst_grant got %0d want 4", gnt_idx); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got %b/%0d/%b/%b want 0/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    req = 8'h11;
    cycle();
    checks++; if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin errors++; $display("FAIL midrst_ptr got %0d want 0", gnt_idx); end
  endtask

  task automatic test_timeout();
    int held;
    bit saw_to;
    do_reset();
    req = 8'b0000_1010;
    cycle();
    checks++; if (gnt_idx !== 3'd1) begin errors++; $display("FAIL to_grant got %0d want 1", gnt_idx); end
    held = 0;
    saw_to = 1'b0;
    while (gnt_valid === 1'b1 && held < 120) begin
      if (timeout === 1'b1) saw_to = 1'b1;
      held++;
      cycle();
    end
    if (TO_EN) begin
      checks++; if (held !== MAXH) begin errors++; $display("FAIL to_hold got %0d want %0d", held, MAXH); end
      checks++; if (timeout !== 1'b1 || saw_to) begin errors++; $display("FAIL to_pulse got %b early %b want 1 0", timeout, saw_to); end
      cycle();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_width got %b want 0", timeout); end
      checks++; if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin errors++; $display("FAIL to_next got %0d/%b want 3/1", gnt_idx, gnt_valid); end
    end else begin
      checks++; if (held !== 120) begin errors++; $display("FAIL to_hold got %0d want 120", held); end
      checks++; if (saw_to || timeout !== 1'b0) begin errors++; $display("FAIL to_never got %b want 0", saw_to); end
      checks++; if (gnt_idx !== 3'd1) begin errors++; $display("FAIL to_owner got %0d want 1", gnt_idx); end
    end
    req = 8'h00;
    cycle();
  endtask

  task automatic test_random();
    logic [7:0] exp_gnt;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      rel = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle();
      exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      checks++;
      if (gnt !== exp_gnt || gnt_idx !== ((m_owner < 0) ? 3'd0 : 3'(m_owner)) ||
          gnt_valid !== (m_owner >= 0) || timeout !== m_to) begin
        errors++;
        $display("FAIL rand cycle %0d got gnt %b idx %0d v %b to %b want gnt %b v %b to %b",
                 n, gnt, gnt_idx, gnt_valid, timeout, exp_gnt, (m_owner >= 0), m_to);
      end
    end
    rst = 1'b0; rel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_and_skip();
    test_round_robin();
    test_implicit_release();
    test_reset_mid_grant();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
